sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter onto one async SRAM: port A (frame) has priority and preempts port B (engine); define SRAM_ARB_STATS_EN for the B-stall counter.
// Latency: SRAM pins driven the cycle after a grant; RData/RValid two edges after the grant; TURN_CYC idle cycles on every owner change.
// Backpressure: Gnt is a same-cycle combinational accept; a requester holds Req/Wr/Addr/WData until it sees Gnt.
module sram_port_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int TURN_CYC = 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iA_Req,
    input  logic              iA_Wr,
    input  logic [ADDR_W-1:0] iA_Addr,
    input  logic [DATA_W-1:0] iA_WData,
    output logic              oA_Gnt,
    output logic [DATA_W-1:0] oA_RData,
    output logic              oA_RValid,
    input  logic              iB_Req,
    input  logic              iB_Wr,
    input  logic [ADDR_W-1:0] iB_Addr,
    input  logic [DATA_W-1:0] iB_WData,
    output logic              oB_Gnt,
    output logic [DATA_W-1:0] oB_RData,
    output logic              oB_RValid,
    output logic [ADDR_W-1:0] oSRAM_Addr,
    inout  wire  [DATA_W-1:0] ioSRAM_Data,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N,
    output logic [15:0]       oConflict_Cnt
);

    typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_TURN} state_t;

    // Turnaround counter is loaded with the last index and counts down to zero.
    localparam logic [2:0] TURN_LAST = 3'(TURN_CYC - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // owner after turnaround: 0 = A, 1 = B
    logic [2:0]        turn_q, turn_d;

    logic              a_gnt, b_gnt;

    // Access stage: the accepted request, driven onto the pins for one cycle.
    logic              acc_vld_q, acc_vld_d;
    logic              acc_wr_q, acc_wr_d;
    logic              acc_port_q, acc_port_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;

    // Return stage: read data captured at the end of the driven cycle.
    logic              rd_vld_q, rd_vld_d;
    logic              rd_port_q, rd_port_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    assign a_gnt  = (state_q == S_A) & iA_Req;
    assign b_gnt  = (state_q == S_B) & iB_Req & ~iA_Req;
    assign oA_Gnt = a_gnt;
    assign oB_Gnt = b_gnt;

    // Ownership FSM: A wins from idle and preempts B; the target is latched on entry to turnaround.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        turn_d  = turn_q;
        case (state_q)
            S_IDLE: begin
                if (iA_Req)      state_d = S_A;
                else if (iB_Req) state_d = S_B;
            end
            S_A: begin
                if (!iA_Req) begin
                    if (iB_Req) begin
                        state_d = S_TURN;
                        owner_d = 1'b1;
                        turn_d  = TURN_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_B: begin
                if (iA_Req) begin
                    state_d = S_TURN;
                    owner_d = 1'b0;
                    turn_d  = TURN_LAST;
                end else if (!iB_Req) begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (turn_q == 3'd0) state_d = owner_q ? S_B : S_A;
                else                turn_d  = turn_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: register the accepted access, then capture read data as it leaves the pins.
    always_comb begin
        acc_vld_d   = a_gnt | b_gnt;
        acc_wr_d    = a_gnt ? iA_Wr : iB_Wr;
        acc_port_d  = b_gnt;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        if (a_gnt) begin
            acc_addr_d  = iA_Addr;
            acc_wdata_d = iA_WData;
        end else if (b_gnt) begin
            acc_addr_d  = iB_Addr;
            acc_wdata_d = iB_WData;
        end
        rd_vld_d  = acc_vld_q & ~acc_wr_q;
        rd_port_d = acc_port_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (acc_vld_q && !acc_wr_q) begin
            if (acc_port_q) b_rdata_d = ioSRAM_Data;
            else            a_rdata_d = ioSRAM_Data;
        end
    end

    // State and pipeline registers; reset discards any in-flight access.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            turn_q      <= 3'd0;
            acc_vld_q   <= 1'b0;
            acc_wr_q    <= 1'b0;
            acc_port_q  <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_port_q   <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            turn_q      <= turn_d;
            acc_vld_q   <= acc_vld_d;
            acc_wr_q    <= acc_wr_d;
            acc_port_q  <= acc_port_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_port_q   <= rd_port_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // Strobes decode straight from the access stage so reset releases them asynchronously.
    assign oSRAM_Addr = acc_addr_q;
    assign oSRAM_CE_N = ~acc_vld_q;
    assign oSRAM_UB_N = ~acc_vld_q;
    assign oSRAM_LB_N = ~acc_vld_q;
    assign oSRAM_WE_N = ~(acc_vld_q & acc_wr_q);
    assign oSRAM_OE_N = ~(acc_vld_q & ~acc_wr_q);
    assign ioSRAM_Data = (acc_vld_q && acc_wr_q) ? acc_wdata_q : {DATA_W{1'bz}};

    assign oA_RData  = a_rdata_q;
    assign oB_RData  = b_rdata_q;
    assign oA_RValid = rd_vld_q & ~rd_port_q;
    assign oB_RValid = rd_vld_q & rd_port_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] conf_q, conf_d;

    // Count cycles where B asks but is not granted, saturating at all-ones.
    always_comb begin
        conf_d = conf_q;
        if (iB_Req && !b_gnt && conf_q != 16'hFFFF) conf_d = conf_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) conf_q <= 16'd0;
        else         conf_q <= conf_d;
    end

    assign oConflict_Cnt = conf_q;
`else
    assign oConflict_Cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed vector table, hand-written reset/saturation sequences, random traffic.
// Reference model tracks ownership, the access/return pipeline and an SRAM shadow memory.
// Inputs driven 1 time unit after the rising edge; outputs sampled 4 units after it.
module tb_sram_port_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TC = 1;
`ifdef SRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic iCLK = 1'b0;
    logic iRST_N;
    logic a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;
    logic a_gnt, b_gnt, a_rv, b_rv;
    logic [DW-1:0] a_rd, b_rd;
    logic [AW-1:0] s_addr;
    wire  [DW-1:0] sram_dq;
    logic ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] conf;

    always #5 iCLK = ~iCLK;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TURN_CYC(TC)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iA_Req(a_req), .iA_Wr(a_wr), .iA_Addr(a_addr), .iA_WData(a_wd),
        .oA_Gnt(a_gnt), .oA_RData(a_rd), .oA_RValid(a_rv),
        .iB_Req(b_req), .iB_Wr(b_wr), .iB_Addr(b_addr), .iB_WData(b_wd),
        .oB_Gnt(b_gnt), .oB_RData(b_rd), .oB_RValid(b_rv),
        .oSRAM_Addr(s_addr), .ioSRAM_Data(sram_dq),
        .oSRAM_CE_N(ce_n), .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n),
        .oSRAM_UB_N(ub_n), .oSRAM_LB_N(lb_n), .oConflict_Cnt(conf)
    );

    // SRAM model: 256 words, drives on read, stores on write at the end of the cycle.
    logic [DW-1:0] mem [256];
    assign sram_dq = (!ce_n && !oe_n) ? mem[s_addr[7:0]] : {DW{1'bz}};
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        forever begin
            @(posedge iCLK);
            if (!ce_n && !we_n) mem[s_addr[7:0]] = sram_dq;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: owner 0 none / 1 A / 2 B, turnaround cycles left, target owner.
    int m_own, m_turn, m_tgt, m_conf;
    bit d_vld, d_wr, d_port;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wd;
    bit m_rva, m_rvb;
    logic [DW-1:0] m_rda, m_rdb;
    logic [DW-1:0] ref_mem [256];
    bit eg_a, eg_b;

    task automatic model_reset();
        m_own = 0; m_turn = 0; m_tgt = 0; m_conf = 0;
        d_vld = 0; d_wr = 0; d_port = 0; d_addr = '0; d_wd = '0;
        m_rva = 0; m_rvb = 0; m_rda = '0; m_rdb = '0;
    endtask

    task automatic step_check();
        #3;
        eg_a = (m_turn == 0) && (m_own == 1) && a_req;
        eg_b = (m_turn == 0) && (m_own == 2) && b_req && !a_req;
        chk1("a_gnt", a_gnt, eg_a);
        chk1("b_gnt", b_gnt, eg_b);
        chk1("ce_n", ce_n, !d_vld);
        chk1("ub_lb_n", ub_n & lb_n, !d_vld);
        chk1("oe_n", oe_n, !(d_vld && !d_wr));
        chk1("we_n", we_n, !(d_vld && d_wr));
        if (d_vld) chkw("sram_addr", 32'(s_addr), 32'(d_addr));
        if (d_vld && d_wr) chkw("sram_wdata", 32'(sram_dq), 32'(d_wd));
        chk1("a_rvalid", a_rv, m_rva);
        chk1("b_rvalid", b_rv, m_rvb);
        chkw("a_rdata", 32'(a_rd), 32'(m_rda));
        chkw("b_rdata", 32'(b_rd), 32'(m_rdb));
        chkw("conflict", 32'(conf), STATS ? 32'(m_conf) : 32'd0);
    endtask

    task automatic step_adv();
        if (b_req && !eg_b && m_conf < 65535) m_conf++;
        m_rva = 0; m_rvb = 0;
        if (d_vld) begin
            if (d_wr) ref_mem[d_addr[7:0]] = d_wd;
            else if (d_port) begin m_rvb = 1; m_rdb = ref_mem[d_addr[7:0]]; end
            else begin m_rva = 1; m_rda = ref_mem[d_addr[7:0]]; end
        end
        d_vld = eg_a || eg_b;
        if (eg_a) begin d_wr = a_wr; d_port = 0; d_addr = a_addr; d_wd = a_wd; end
        else if (eg_b) begin d_wr = b_wr; d_port = 1; d_addr = b_addr; d_wd = b_wd; end
        if (m_turn > 0) begin
            m_turn--;
            if (m_turn == 0) m_own = m_tgt;
        end else begin
            case (m_own)
                0: if (a_req) m_own = 1; else if (b_req) m_own = 2;
                1: if (!a_req) begin
                       if (b_req) begin m_turn = TC; m_tgt = 2; end
                       else m_own = 0;
                   end
                default: if (a_req) begin m_turn = TC; m_tgt = 1; end
                         else if (!b_req) m_own = 0;
            endcase
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_wr = 0; a_addr = '0; a_wd = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wd = '0;
    endtask

    typedef struct {
        logic a_req, a_wr; logic [7:0] a_addr;
        logic b_req, b_wr; logic [7:0] b_addr; logic [15:0] b_wd;
        logic e_ag, e_bg, e_ce, e_oe, e_we, e_arv, e_brv;
    } vec_t;
    vec_t tbl [29];

    task automatic setv(input int i, input int ar, input int aa, input int br, input int bw,
                        input int ba, input int bd, input int eag, input int ebg,
                        input int ece, input int eoe, input int ewe, input int earv, input int ebrv);
        tbl[i].a_req = ar[0]; tbl[i].a_wr = 1'b0; tbl[i].a_addr = aa[7:0];
        tbl[i].b_req = br[0]; tbl[i].b_wr = bw[0]; tbl[i].b_addr = ba[7:0]; tbl[i].b_wd = bd[15:0];
        tbl[i].e_ag = eag[0]; tbl[i].e_bg = ebg[0]; tbl[i].e_ce = ece[0];
        tbl[i].e_oe = eoe[0]; tbl[i].e_we = ewe[0]; tbl[i].e_arv = earv[0]; tbl[i].e_brv = ebrv[0];
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 + 16'(i);
        //      i  ar  aa    br bw ba    bd       ag bg ce oe we arv brv
        // A-only: three back-to-back reads
        setv( 0, 1, 'h10, 0, 0, 0,    0,       0, 0, 1, 1, 1, 0, 0);
        setv( 1, 1, 'h10, 0, 0, 0,    0,       1, 0, 1, 1, 1, 0, 0);
        setv( 2, 1, 'h11, 0, 0, 0,    0,       1, 0, 0, 0, 1, 0, 0);
        setv( 3, 1, 'h12, 0, 0, 0,    0,       1, 0, 0, 0, 1, 1, 0);
        setv( 4, 0, 0,    0, 0, 0,    0,       0, 0, 0, 0, 1, 1, 0);
        setv( 5, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 1, 0);
        setv( 6, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 0, 0);
        // B write stream preempted by A
        setv( 7, 0, 0,    1, 1, 'h20, 'h1111,  0, 0, 1, 1, 1, 0, 0);
        setv( 8, 0, 0,    1, 1, 'h20, 'h1111,  0, 1, 1, 1, 1, 0, 0);
        setv( 9, 0, 0,    1, 1, 'h21, 'h2222,  0, 1, 0, 1, 0, 0, 0);
        setv(10, 0, 0,    1, 1, 'h22, 'h3333,  0, 1, 0, 1, 0, 0, 0);
        setv(11, 1, 'h30, 1, 1, 'h23, 'h4444,  0, 0, 0, 1, 0, 0, 0);
        setv(12, 1, 'h30, 1, 1, 'h23, 'h4444,  0, 0, 1, 1, 1, 0, 0);
        setv(13, 1, 'h30, 1, 1, 'h23, 'h4444,  1, 0, 1, 1, 1, 0, 0);
        setv(14, 0, 0,    0, 0, 0,    0,       0, 0, 0, 0, 1, 0, 0);
        setv(15, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 1, 0);
        setv(16, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 0, 0);
        // Simultaneous requests, then B read in flight while A requests
        setv(17, 1, 'h40, 1, 0, 'h50, 0,       0, 0, 1, 1, 1, 0, 0);
        setv(18, 1, 'h40, 1, 0, 'h50, 0,       1, 0, 1, 1, 1, 0, 0);
        setv(19, 1, 'h40, 1, 0, 'h50, 0,       1, 0, 0, 0, 1, 0, 0);
        setv(20, 0, 0,    1, 0, 'h50, 0,       0, 0, 0, 0, 1, 1, 0);
        setv(21, 0, 0,    1, 0, 'h50, 0,       0, 0, 1, 1, 1, 1, 0);
        setv(22, 0, 0,    1, 0, 'h50, 0,       0, 1, 1, 1, 1, 0, 0);
        setv(23, 1, 'h41, 0, 0, 0,    0,       0, 0, 0, 0, 1, 0, 0);
        setv(24, 1, 'h41, 0, 0, 0,    0,       0, 0, 1, 1, 1, 0, 1);
        setv(25, 1, 'h41, 0, 0, 0,    0,       1, 0, 1, 1, 1, 0, 0);
        setv(26, 0, 0,    0, 0, 0,    0,       0, 0, 0, 0, 1, 0, 0);
        setv(27, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 1, 0);
        setv(28, 0, 0,    0, 0, 0,    0,       0, 0, 1, 1, 1, 0, 0);

        // Reset state, with A requesting to show no grant leaks through reset
        idle_inputs();
        a_req = 1;
        iRST_N = 0;
        #2;
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_ce_n", ce_n, 1'b1);
        chk1("rst_oe_n", oe_n, 1'b1);
        chk1("rst_we_n", we_n, 1'b1);
        chk1("rst_ub_lb_n", ub_n & lb_n, 1'b1);
        chkw("rst_addr", 32'(s_addr), 32'd0);
        chk1("rst_rvalid", a_rv | b_rv, 1'b0);
        chkw("rst_rdata", 32'({a_rd, b_rd}), 32'd0);
        chkw("rst_conflict", 32'(conf), 32'd0);
        idle_inputs();
        #10 iRST_N = 1;
        @(posedge iCLK);
        #1;
        model_reset();

        // Directed table
        for (int i = 0; i < 29; i++) begin
            a_req = tbl[i].a_req; a_wr = tbl[i].a_wr; a_addr = 20'(tbl[i].a_addr); a_wd = '0;
            b_req = tbl[i].b_req; b_wr = tbl[i].b_wr; b_addr = 20'(tbl[i].b_addr); b_wd = tbl[i].b_wd;
            step_check();
            chk1($sformatf("v%0d_a_gnt", i), a_gnt, tbl[i].e_ag);
            chk1($sformatf("v%0d_b_gnt", i), b_gnt, tbl[i].e_bg);
            chk1($sformatf("v%0d_ce_n", i), ce_n, tbl[i].e_ce);
            chk1($sformatf("v%0d_oe_n", i), oe_n, tbl[i].e_oe);
            chk1($sformatf("v%0d_we_n", i), we_n, tbl[i].e_we);
            chk1($sformatf("v%0d_a_rvalid", i), a_rv, tbl[i].e_arv);
            chk1($sformatf("v%0d_b_rvalid", i), b_rv, tbl[i].e_brv);
            step_adv();
        end
        chkw("mem_20", 32'(mem[8'h20]), 32'h1111);
        chkw("mem_21", 32'(mem[8'h21]), 32'h2222);
        chkw("mem_22", 32'(mem[8'h22]), 32'h3333);
        chkw("mem_23_not_issued", 32'(mem[8'h23]), 32'hA023);
        chkw("b_rdata_hold", 32'(b_rd), 32'hA050);
        chkw("a_rdata_hold", 32'(a_rd), 32'hA041);
        chkw("table_conflict", 32'(conf), STATS ? 32'd9 : 32'd0);

        // Reset during a read driven cycle: the read must never return
        idle_inputs();
        a_req = 1; a_addr = 20'h60;
        step_check(); step_adv();
        step_check(); step_adv();
        idle_inputs();
        #3;
        chk1("rd_inflight_oe_n", oe_n, 1'b0);
        iRST_N = 0;
        #1;
        chk1("rd_rst_oe_n", oe_n, 1'b1);
        chk1("rd_rst_ce_n", ce_n, 1'b1);
        @(posedge iCLK);
        #4 iRST_N = 1;
        model_reset();
        @(posedge iCLK);
        #1;
        for (int i = 0; i < 3; i++) begin step_check(); step_adv(); end

        // Reset during a write driven cycle: WE_N releases at once and the write is lost
        a_req = 1; a_wr = 1; a_addr = 20'h61; a_wd = 16'hBEEF;
        step_check(); step_adv();
        step_check(); step_adv();
        idle_inputs();
        #3;
        chk1("wr_inflight_we_n", we_n, 1'b0);
        chkw("wr_inflight_data", 32'(sram_dq), 32'hBEEF);
        iRST_N = 0;
        #1;
        chk1("wr_rst_we_n", we_n, 1'b1);
        chk1("wr_rst_ce_n", ce_n, 1'b1);
        chkw("wr_rst_addr", 32'(s_addr), 32'd0);
        @(posedge iCLK);
        #4 iRST_N = 1;
        model_reset();
        @(posedge iCLK);
        #1;
        for (int i = 0; i < 3; i++) begin step_check(); step_adv(); end
        chkw("wr_rst_mem_61", 32'(mem[8'h61]), 32'hA061);

        // Random traffic with varying request densities
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 400; c++) begin
                a_req = ($urandom_range(0, 99) < 20 + seg * 20);
                b_req = ($urandom_range(0, 99) < 80 - seg * 15);
                a_wr = 1'($urandom_range(0, 1));
                b_wr = 1'($urandom_range(0, 1));
                a_addr = 20'(8'h80 + $urandom_range(0, 15));
                b_addr = 20'(8'h80 + $urandom_range(0, 15));
                a_wd = 16'($urandom);
                b_wd = 16'($urandom);
                step_check();
                step_adv();
            end
        end

        // Saturation: B stalled behind A for 70000 cycles
        idle_inputs();
        iRST_N = 0;
        #3;
        a_req = 1; b_req = 1;
        iRST_N = 1;
        repeat (1000) @(posedge iCLK);
        #1;
        chkw("sat_1000", 32'(conf), STATS ? 32'd1000 : 32'd0);
        repeat (64535) @(posedge iCLK);
        #1;
        chkw("sat_65535", 32'(conf), STATS ? 32'h0000FFFF : 32'd0);
        repeat (4465) @(posedge iCLK);
        #1;
        chkw("sat_70000", 32'(conf), STATS ? 32'h0000FFFF : 32'd0);
        chk1("sat_b_gnt", b_gnt, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
